la_fifo_mport: RTL and testbench

LA_FIFO_MPORT -- requirements
Module: la_fifo_mport

---
 rtl/la_fifo_mport.sv | 116 +++++++++++
 tb/tb_la_fifo_mport.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/la_fifo_mport.sv
// Multi-port FIFO: up to WR_PORTS pushes and RD_PORTS pops per cycle, all-or-nothing push groups.
// Every output is derived from registered state; any DEPTH >= max(WR_PORTS, RD_PORTS) is supported.
module la_fifo_mport #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WR_PORTS   = 2,
    parameter int unsigned RD_PORTS   = 2,
    parameter int unsigned AF_THRESH  = DEPTH - WR_PORTS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush_i,
    input  logic [WR_PORTS-1:0]                  push_i,
    input  logic [WR_PORTS-1:0][DATA_WIDTH-1:0]  data_i,
    input  logic [RD_PORTS-1:0]                  pop_i,
    output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  data_o,
    output logic [RD_PORTS-1:0]                  valid_o,
    output logic [$clog2(DEPTH+1)-1:0]           usage_o,
    output logic [$clog2(DEPTH+1)-1:0]           free_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic                                 almost_full_o,
    output logic                                 overflow_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = PW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_usage;
    logic                  r_overflow;

    logic [CW-1:0]         w_free;
    logic [CW-1:0]         w_push_cnt;
    logic [CW-1:0]         w_push_acc_cnt;
    logic [CW-1:0]         w_pop_cnt;
    logic                  w_push_ok;
    logic [RD_PORTS-1:0]   w_pop_acc;
    logic [PW-1:0]         w_wr_idx [WR_PORTS];
    logic [PW-1:0]         w_rd_idx [RD_PORTS];

    // Pointer + n never reaches 2*DEPTH, so one conditional subtract wraps any DEPTH.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [CW-1:0] n);
        logic [SW-1:0] sum;
        sum = {1'b0, ptr} + SW'(n);
        if (sum >= SW'(DEPTH)) begin
            sum = sum - SW'(DEPTH);
        end
        return sum[PW-1:0];
    endfunction

    always_comb begin
        for (int k = 0; k < RD_PORTS; k++) begin
            valid_o[k]  = (r_usage > CW'(k));
            w_rd_idx[k] = wrap_add(r_rd_ptr, CW'(k));
            data_o[k]   = r_mem[w_rd_idx[k]];
        end
    end

    assign usage_o       = r_usage;
    assign free_o        = w_free;
    assign full_o        = (r_usage == CW'(DEPTH));
    assign empty_o       = (r_usage == '0);
    assign almost_full_o = (32'(r_usage) >= AF_THRESH);
    assign overflow_o    = r_overflow;

    always_comb begin
        w_free     = CW'(DEPTH) - r_usage;
        w_push_cnt = '0;
        for (int k = 0; k < WR_PORTS; k++) begin
            w_push_cnt = w_push_cnt + CW'(push_i[k]);
            w_wr_idx[k] = wrap_add(r_wr_ptr, CW'(k));
        end
        // Room is judged on registered free space; same-cycle pops do not help.
        w_push_ok      = !flush_i && (w_push_cnt <= w_free);
        w_push_acc_cnt = w_push_ok ? w_push_cnt : '0;
        w_pop_acc      = pop_i & valid_o;
        w_pop_cnt      = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            w_pop_cnt = w_pop_cnt + CW'(w_pop_acc[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_usage    <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_usage    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= !w_push_ok;
            r_wr_ptr   <= wrap_add(r_wr_ptr, w_push_acc_cnt);
            r_rd_ptr   <= wrap_add(r_rd_ptr, w_pop_cnt);
            r_usage    <= r_usage + w_push_acc_cnt - w_pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            for (int k = 0; k < WR_PORTS; k++) begin
                if (push_i[k]) begin
                    r_mem[w_wr_idx[k]] <= data_i[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_la_fifo_mport.sv
// Directed bench for la_fifo_mport (DEPTH=6, 2 write / 2 read lanes, AF_THRESH=4).
// Stimulus queues expected pop data; a negedge monitor pops and compares accepted read lanes.
module tb_la_fifo_mport;

    localparam int unsigned DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush_i = 1'b0;
    logic [1:0]        push_i = '0;
    logic [1:0][DW-1:0] data_i = '0;
    logic [1:0]        pop_i = '0;
    logic [1:0][DW-1:0] data_o;
    logic [1:0]        valid_o;
    logic [2:0]        usage_o;
    logic [2:0]        free_o;
    logic              full_o;
    logic              empty_o;
    logic              almost_full_o;
    logic              overflow_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q [$];

    la_fifo_mport #(
        .DATA_WIDTH (DW),
        .DEPTH      (6),
        .WR_PORTS   (2),
        .RD_PORTS   (2),
        .AF_THRESH  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .push_i        (push_i),
        .data_i        (data_i),
        .pop_i         (pop_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .usage_o       (usage_o),
        .free_o        (free_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Status snapshot: usage, free, empty, full, almost_full, overflow, valid.
    task automatic chk_status(input string tag, input int u, input bit ovf);
        chk({tag, " usage"}, 32'(usage_o), 32'(u));
        chk({tag, " free"}, 32'(free_o), 32'(6 - u));
        chk({tag, " empty"}, 32'(empty_o), 32'(u == 0));
        chk({tag, " full"}, 32'(full_o), 32'(u == 6));
        chk({tag, " afull"}, 32'(almost_full_o), 32'(u >= 4));
        chk({tag, " overflow"}, 32'(overflow_o), 32'(ovf));
        chk({tag, " valid"}, 32'(valid_o), (u >= 2) ? 32'd3 : 32'(u));
    endtask

    // Drive one cycle of inputs; acc is the hand-decided acceptance of the push group.
    task automatic tick(input logic [1:0] push, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [1:0] pop, input logic flush, input bit acc);
        push_i    = push;
        data_i[0] = a;
        data_i[1] = b;
        pop_i     = pop;
        flush_i   = flush;
        if (flush) begin
            exp_q.delete();
        end else if (acc) begin
            if (push[0]) exp_q.push_back(a);
            if (push[1]) exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        push_i  = '0;
        pop_i   = '0;
        flush_i = 1'b0;
    endtask

    always @(negedge clk) begin
        assert ((push_i & (push_i + 2'd1)) == 2'b00) else $error("FAIL push_i not a prefix mask");
        assert ((pop_i & (pop_i + 2'd1)) == 2'b00) else $error("FAIL pop_i not a prefix mask");
        if (rst_n && !flush_i) begin
            for (int k = 0; k < 2; k++) begin
                if (pop_i[k] && valid_o[k]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("sb lane%0d underflow", k), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("sb lane%0d data", k), 32'(data_o[k]), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_status("reset", 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two-lane push from empty
        tick(2'b11, 16'h0A01, 16'h0B02, 2'b00, 1'b0, 1'b1);
        chk_status("push2", 2, 1'b0);
        chk("push2 data0", 32'(data_o[0]), 32'h0A01);
        chk("push2 data1", 32'(data_o[1]), 32'h0B02);

        // Fill to 5, reject a 2-lane group, then top off to full
        tick(2'b11, 16'h0C03, 16'h0D04, 2'b00, 1'b0, 1'b1);
        chk_status("fill4", 4, 1'b0);
        tick(2'b01, 16'h0E05, 16'h0000, 2'b00, 1'b0, 1'b1);
        chk_status("fill5", 5, 1'b0);
        tick(2'b11, 16'h0F06, 16'h1007, 2'b00, 1'b0, 1'b0);
        chk_status("reject", 5, 1'b1);
        tick(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1);
        chk_status("ovf pulse end", 5, 1'b0);
        tick(2'b01, 16'h1108, 16'h0000, 2'b00, 1'b0, 1'b1);
        chk_status("full", 6, 1'b0);

        // Same-cycle pops do not make room for pushes
        tick(2'b11, 16'h1209, 16'h130A, 2'b11, 1'b0, 1'b0);
        chk_status("full pop+push", 4, 1'b1);
        tick(2'b11, 16'h140B, 16'h150C, 2'b11, 1'b0, 1'b1);
        chk_status("4 pop+push", 4, 1'b0);
        chk("order data0", 32'(data_o[0]), 32'h0E05);
        chk("order data1", 32'(data_o[1]), 32'h1108);

        // Streaming through the wrap point
        for (int i = 0; i < 20; i++) begin
            tick(2'b11, 16'(16'h2000 + 2 * i), 16'(16'h2001 + 2 * i), 2'b11, 1'b0, 1'b1);
        end
        chk_status("stream", 4, 1'b0);
        tick(2'b00, 16'h0000, 16'h0000, 2'b11, 1'b0, 1'b1);
        tick(2'b00, 16'h0000, 16'h0000, 2'b11, 1'b0, 1'b1);
        chk_status("drained", 0, 1'b0);

        // Two-lane pop with a single entry
        tick(2'b01, 16'h3001, 16'h0000, 2'b00, 1'b0, 1'b1);
        chk_status("one entry", 1, 1'b0);
        chk("one entry data0", 32'(data_o[0]), 32'h3001);
        tick(2'b00, 16'h0000, 16'h0000, 2'b11, 1'b0, 1'b1);
        chk_status("over-pop", 0, 1'b0);

        // Flush beats a concurrent push
        tick(2'b11, 16'h4001, 16'h4002, 2'b00, 1'b0, 1'b1);
        tick(2'b01, 16'h4003, 16'h0000, 2'b00, 1'b0, 1'b1);
        chk_status("pre-flush", 3, 1'b0);
        tick(2'b11, 16'h4004, 16'h4005, 2'b00, 1'b1, 1'b0);
        chk_status("flush", 0, 1'b0);
        tick(2'b01, 16'h5001, 16'h0000, 2'b00, 1'b0, 1'b1);
        chk_status("post-flush", 1, 1'b0);
        chk("post-flush data0", 32'(data_o[0]), 32'h5001);

        // Asynchronous reset mid-stream, while overflow is high
        tick(2'b11, 16'h6001, 16'h6002, 2'b00, 1'b0, 1'b1);
        tick(2'b11, 16'h6003, 16'h6004, 2'b00, 1'b0, 1'b1);
        tick(2'b11, 16'h6005, 16'h6006, 2'b00, 1'b0, 1'b0);
        chk_status("pre-reset", 5, 1'b1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 chk_status("async reset", 0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2'b01, 16'h7001, 16'h0000, 2'b00, 1'b0, 1'b1);
        chk_status("post-reset push", 1, 1'b0);
        chk("post-reset data0", 32'(data_o[0]), 32'h7001);
        tick(2'b00, 16'h0000, 16'h0000, 2'b01, 1'b0, 1'b1);
        chk_status("final", 0, 1'b0);
        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
